// File: rtl/npi_rd_engine.sv
// npi_rd_engine
//   Read-only NPI master. Accepts one read request at a time (byte address plus
//   NPI Size code 0..4), issues a single address phase to the MPMC, then pops the
//   MPMC read FIFO into a small output buffer. The buffer is drained as a beat
//   stream with backpressure.
//
// Ports
//   Clk, Rst           : single clock; asynchronous active-high reset
//   req_valid/ready    : request handshake (req_addr, req_size)
//   req_err            : one-cycle pulse when an accepted request is illegal
//   rd_data/valid/ready/last : output beat stream, rd_last on the final beat
//   busy               : state is not IDLE
//   PIM_*              : NPI master side (address phase, read FIFO, init status)
module npi_rd_engine #(
  parameter int C_PIM_DATA_WIDTH = 64,
  parameter int C_BUF_DEPTH      = 4
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [31:0]                 req_addr,
  input  logic [2:0]                  req_size,
  output logic                        req_err,
  output logic [C_PIM_DATA_WIDTH-1:0] rd_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic                        rd_last,
  output logic                        busy,
  output logic [31:0]                 PIM_Addr,
  output logic                        PIM_AddrReq,
  input  logic                        PIM_AddrAck,
  output logic                        PIM_RNW,
  output logic [3:0]                  PIM_Size,
  output logic                        PIM_RdModWr,
  input  logic [C_PIM_DATA_WIDTH-1:0] PIM_RdFIFO_Data,
  output logic                        PIM_RdFIFO_Pop,
  input  logic                        PIM_RdFIFO_Empty,
  input  logic [1:0]                  PIM_RdFIFO_Latency,
  output logic                        PIM_RdFIFO_Flush,
  input  logic                        PIM_InitDone
);

  localparam logic [1:0] S_FLUSH = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_ADDR  = 2'd2;
  localparam logic [1:0] S_DATA  = 2'd3;

  localparam int PW = $clog2(C_BUF_DEPTH);
  localparam int CW = $clog2(C_BUF_DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(C_BUF_DEPTH - 1);
  localparam logic [CW+1:0] DEPTH_V  = (CW+2)'(C_BUF_DEPTH);

  function automatic logic [4:0] beatsOf(input logic [2:0] size);
    beatsOf = 5'd1 << size;
  endfunction

  // The MPMC encoding has no latency 3; treat it as the longest real one.
  function automatic logic [1:0] satLatency(input logic [1:0] lat);
    satLatency = (lat == 2'd3) ? 2'd2 : lat;
  endfunction

  // Legal when the size code is 0..4 and the address is aligned to the burst.
  function automatic logic reqLegal(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] mask;
    mask     = ({27'd0, beatsOf(size)} << 3) - 32'd1;
    reqLegal = (size <= 3'd4) && ((addr & mask) == 32'd0);
  endfunction

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    nextPtr = (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  logic [1:0]                  state;
  logic [31:0]                 addrReg;
  logic [2:0]                  sizeReg;
  logic [1:0]                  latency;
  logic [4:0]                  popsLeft;
  logic [4:0]                  readsLeft;
  logic                        popVld_p1;
  logic                        popVld_p2;
  logic [PW-1:0]               wrPtr;
  logic [PW-1:0]               rdPtr;
  logic [CW-1:0]               occupancy;
  logic [C_PIM_DATA_WIDTH-1:0] mem [C_BUF_DEPTH];

  logic          accept;
  logic          legal;
  logic [1:0]    inFlight;
  logic [CW+1:0] committed;
  logic          bufWr;
  logic          bufRd;

  assign accept = req_valid && req_ready;
  assign legal  = reqLegal(req_addr, req_size);

  // Rst gates the two outputs that would otherwise reflect the FLUSH reset state.
  assign req_ready        = (state == S_IDLE) && PIM_InitDone;
  assign req_err          = accept && !legal;
  assign busy             = (state != S_IDLE) && !Rst;
  assign PIM_RdFIFO_Flush = (state == S_FLUSH) && !Rst;
  assign PIM_AddrReq      = (state == S_ADDR);
  assign PIM_Addr         = addrReg;
  assign PIM_Size         = {1'b0, sizeReg};
  assign PIM_RNW          = 1'b1;
  assign PIM_RdModWr      = 1'b0;

  // Pops already issued whose data has not yet landed in the buffer.
  always_comb begin
    inFlight = 2'd0;
    case (latency)
      2'd0:    inFlight = 2'd0;
      2'd1:    inFlight = {1'b0, popVld_p1};
      default: inFlight = {1'b0, popVld_p1} + {1'b0, popVld_p2};
    endcase
  end

  // A pop is only issued if its data is guaranteed a buffer slot on arrival.
  assign committed      = {2'b00, occupancy} + {{CW{1'b0}}, inFlight};
  assign PIM_RdFIFO_Pop = (state == S_DATA) && !PIM_RdFIFO_Empty &&
                          (popsLeft != 5'd0) && (committed < DEPTH_V);

  always_comb begin
    bufWr = 1'b0;
    case (latency)
      2'd0:    bufWr = PIM_RdFIFO_Pop;
      2'd1:    bufWr = popVld_p1;
      default: bufWr = popVld_p2;
    endcase
  end

  assign bufRd    = rd_valid && rd_ready;
  assign rd_valid = (occupancy != '0);
  assign rd_data  = mem[rdPtr];
  assign rd_last  = rd_valid && (readsLeft == 5'd1);

  // Stage p0 -> p1 -> p2: pop issue delayed to match the MPMC read latency.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      popVld_p1 <= 1'b0;
      popVld_p2 <= 1'b0;
    end else begin
      popVld_p1 <= PIM_RdFIFO_Pop;
      popVld_p2 <= popVld_p1;
    end
  end

  // Buffer write stage: FIFO data lands here at pop + latency.
  always_ff @(posedge Clk) begin
    if (bufWr) mem[wrPtr] <= PIM_RdFIFO_Data;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (bufWr) wrPtr <= nextPtr(wrPtr);
      if (bufRd) rdPtr <= nextPtr(rdPtr);
      case ({bufWr, bufRd})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= S_FLUSH;
      addrReg   <= '0;
      sizeReg   <= '0;
      latency   <= '0;
      popsLeft  <= '0;
      readsLeft <= '0;
    end else begin
      case (state)
        S_FLUSH: state <= S_IDLE;
        S_IDLE: begin
          if (accept && legal) begin
            state     <= S_ADDR;
            addrReg   <= req_addr;
            sizeReg   <= req_size;
            latency   <= satLatency(PIM_RdFIFO_Latency);
            popsLeft  <= beatsOf(req_size);
            readsLeft <= beatsOf(req_size);
          end
        end
        S_ADDR: begin
          if (PIM_AddrAck) state <= S_DATA;
        end
        default: begin
          if (PIM_RdFIFO_Pop) popsLeft <= popsLeft - 5'd1;
          if (bufRd) readsLeft <= readsLeft - 5'd1;
          if (bufRd && rd_last) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npi_rd_engine.sv
// tb_npi_rd_engine
//   Self-checking bench for npi_rd_engine. A behavioural MPMC responder serves
//   the read FIFO with a configurable latency and Empty pattern; expected beats
//   are the responder's own word list in pop order.
module tb_npi_rd_engine;
  localparam int DEPTH = 4;

  logic        Clk;
  logic        Rst;
  logic        req_valid, req_ready, req_err;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [63:0] rd_data;
  logic        rd_valid, rd_ready, rd_last, busy;
  logic [31:0] PIM_Addr;
  logic        PIM_AddrReq, PIM_AddrAck, PIM_RNW, PIM_RdModWr;
  logic [3:0]  PIM_Size;
  logic [63:0] PIM_RdFIFO_Data;
  logic        PIM_RdFIFO_Pop, PIM_RdFIFO_Empty, PIM_RdFIFO_Flush, PIM_InitDone;
  logic [1:0]  PIM_RdFIFO_Latency;

  npi_rd_engine #(.C_PIM_DATA_WIDTH(64), .C_BUF_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_err(req_err),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .busy(busy),
    .PIM_Addr(PIM_Addr), .PIM_AddrReq(PIM_AddrReq), .PIM_AddrAck(PIM_AddrAck),
    .PIM_RNW(PIM_RNW), .PIM_Size(PIM_Size), .PIM_RdModWr(PIM_RdModWr),
    .PIM_RdFIFO_Data(PIM_RdFIFO_Data), .PIM_RdFIFO_Pop(PIM_RdFIFO_Pop),
    .PIM_RdFIFO_Empty(PIM_RdFIFO_Empty), .PIM_RdFIFO_Latency(PIM_RdFIFO_Latency),
    .PIM_RdFIFO_Flush(PIM_RdFIFO_Flush), .PIM_InitDone(PIM_InitDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int nChecks = 0;
  int nFails  = 0;

  // MPMC read FIFO model: pop k returns words[k], presented `mpmcLat` cycles later.
  logic [63:0] words [64];
  int mpmcLat   = 0;
  int emptyMode = 0;
  bit mpmcClear = 0;
  int popIdx = 0, hist1 = -1, hist2 = -1, popWhileEmpty = 0;

  initial begin
    bit popNow;
    int k;
    forever begin
      @(negedge Clk);
      popNow = PIM_RdFIFO_Pop;
      if (popNow && PIM_RdFIFO_Empty) popWhileEmpty++;
      @(posedge Clk);
      #2;
      if (mpmcClear) begin
        popIdx = 0; hist1 = -1; hist2 = -1; mpmcClear = 0;
      end else begin
        hist2 = hist1;
        hist1 = popNow ? popIdx : -1;
        if (popNow) popIdx++;
      end
      case (mpmcLat)
        0:       k = popIdx;
        1:       k = hist1;
        default: k = hist2;
      endcase
      PIM_RdFIFO_Data = (k >= 0) ? words[k % 64] : {$urandom, $urandom};
      case (emptyMode)
        0:       PIM_RdFIFO_Empty = 1'b0;
        1:       PIM_RdFIFO_Empty = ~PIM_RdFIFO_Empty;
        default: PIM_RdFIFO_Empty = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Observations from the most recent run_read.
  logic [63:0] gotData [$];
  bit          gotLast [$];
  int          obsPops, obsMaxOut, obsReqCycles, obsPopInAddr, obsAckDelay;
  logic [31:0] obsAddr;
  logic [3:0]  obsSize;
  bit          obsUnstable, obsNotIdleAfter, obsTimeout, obsErr;

  // Drives one request and records what the DUT does; called at posedge+1.
  task automatic run_read(input logic [31:0] addr, input logic [2:0] size, input int lat,
                          input int readyMode, input int stall, input int eMode,
                          input int abortAfter, input bit dropInit);
    int beats, cyc, acc;
    bit acked, seenReq;
    beats = 1 << size;
    for (int i = 0; i < 64; i++) words[i] = {$urandom, $urandom};
    mpmcClear = 1; mpmcLat = (lat == 3) ? 2 : lat; emptyMode = eMode;
    PIM_RdFIFO_Latency = 2'(lat);
    gotData.delete(); gotLast.delete();
    obsPops = 0; obsMaxOut = 0; obsReqCycles = 0; obsPopInAddr = 0;
    obsAddr = '0; obsSize = '0; obsUnstable = 0; obsNotIdleAfter = 0; obsTimeout = 0; obsErr = 0;
    obsAckDelay = $urandom_range(0, 3);
    req_valid = 1; req_addr = addr; req_size = size;
    cyc = 0;
    @(negedge Clk);
    while (!req_ready && cyc < 50) begin
      @(negedge Clk);
      cyc++;
    end
    if (!req_ready) begin
      obsTimeout = 1; req_valid = 0;
      return;
    end
    obsErr = req_err;
    @(posedge Clk); #1;
    req_valid = 0;
    if (dropInit) PIM_InitDone = 0;
    acked = 0; seenReq = 0; acc = 0; cyc = 0;
    while (acc < beats && !(abortAfter > 0 && acc >= abortAfter) && cyc < 500) begin
      PIM_AddrAck = !acked && (cyc >= obsAckDelay);
      case (readyMode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc >= stall);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge Clk);
      if (PIM_AddrReq) begin
        obsReqCycles++;
        if (!seenReq) begin obsAddr = PIM_Addr; obsSize = PIM_Size; seenReq = 1; end
        else if (PIM_Addr !== obsAddr || PIM_Size !== obsSize) obsUnstable = 1;
        if (PIM_AddrAck) acked = 1;
      end
      if (PIM_RdFIFO_Pop) begin
        obsPops++;
        if (PIM_AddrReq) obsPopInAddr++;
      end
      if (rd_valid && rd_ready) begin
        gotData.push_back(rd_data); gotLast.push_back(rd_last); acc++;
      end
      if (obsPops - acc > obsMaxOut) obsMaxOut = obsPops - acc;
      cyc++;
      @(posedge Clk); #1;
    end
    PIM_AddrAck = 0;
    if (cyc >= 500) obsTimeout = 1;
    if (abortAfter > 0 && acc >= abortAfter) return;
    @(negedge Clk);
    obsNotIdleAfter = busy || !req_ready;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    int stray;
    #1 Rst = 1;
    #1;
    nChecks++;
    if ({req_ready, req_err, rd_valid, rd_last, busy, PIM_AddrReq, PIM_RdFIFO_Pop,
         PIM_RdFIFO_Flush, PIM_RdModWr} !== 9'b0 || PIM_RNW !== 1'b1 ||
        PIM_Addr !== 32'h0 || PIM_Size !== 4'h0) begin
      nFails++;
      $display("FAIL reset_outputs: ready=%0b err=%0b vld=%0b last=%0b busy=%0b areq=%0b pop=%0b flush=%0b rnw=%0b addr=%h size=%h, want all 0 with rnw=1",
               req_ready, req_err, rd_valid, rd_last, busy, PIM_AddrReq, PIM_RdFIFO_Pop,
               PIM_RdFIFO_Flush, PIM_RNW, PIM_Addr, PIM_Size);
    end
    repeat (2) @(posedge Clk);
    #1 Rst = 0;
    @(negedge Clk);
    nChecks++;
    if ({PIM_RdFIFO_Flush, busy, req_ready} !== 3'b110) begin
      nFails++;
      $display("FAIL reset_flush_cycle: flush/busy/ready=%b, want 110", {PIM_RdFIFO_Flush, busy, req_ready});
    end
    @(posedge Clk); #1;
    @(negedge Clk);
    nChecks++;
    if ({PIM_RdFIFO_Flush, busy, req_ready} !== 3'b001) begin
      nFails++;
      $display("FAIL reset_idle_cycle: flush/busy/ready=%b, want 001", {PIM_RdFIFO_Flush, busy, req_ready});
    end
    stray = 0;
    repeat (4) begin
      @(negedge Clk);
      stray += int'(PIM_RdFIFO_Pop) + int'(PIM_AddrReq) + int'(PIM_RdFIFO_Flush);
    end
    nChecks++;
    if (stray != 0) begin
      nFails++;
      $display("FAIL reset_quiet: %0d pop/addrreq/flush cycles, want 0", stray);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_basic();
    run_read(32'h100, 3'd3, 1, 0, 0, 0, 0, 1'b0);
    nChecks++;
    if (obsTimeout || gotData.size() != 8) begin
      nFails++;
      $display("FAIL basic_beats: got %0d beats timeout=%0b, want 8", gotData.size(), obsTimeout);
    end
    for (int i = 0; i < gotData.size(); i++) begin
      nChecks++;
      if (gotData[i] !== words[i] || gotLast[i] != (i == 7)) begin
        nFails++;
        $display("FAIL basic_beat%0d: data %h last %0b, want %h last %0b", i, gotData[i], gotLast[i], words[i], i == 7);
      end
    end
    nChecks++;
    if (obsPops != 8 || obsPopInAddr != 0) begin
      nFails++;
      $display("FAIL basic_pops: pops %0d (in ADDR %0d), want 8 (0)", obsPops, obsPopInAddr);
    end
    nChecks++;
    if (obsReqCycles != obsAckDelay + 1 || obsUnstable) begin
      nFails++;
      $display("FAIL basic_addrreq: %0d cycles unstable=%0b, want %0d stable", obsReqCycles, obsUnstable, obsAckDelay + 1);
    end
    nChecks++;
    if (obsAddr !== 32'h100 || obsSize !== 4'd3) begin
      nFails++;
      $display("FAIL basic_addr: addr %h size %0d, want 100 size 3", obsAddr, obsSize);
    end
    nChecks++;
    if (obsNotIdleAfter || obsErr) begin
      nFails++;
      $display("FAIL basic_idle_after: notIdle=%0b err=%0b, want 0 0", obsNotIdleAfter, obsErr);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    a = $urandom & ~32'h7F;
    run_read(a, 3'd4, 2, 1, 20, 0, 0, 1'b0);
    nChecks++;
    if (obsTimeout || gotData.size() != 16 || obsPops != 16) begin
      nFails++;
      $display("FAIL bp_beats: beats %0d pops %0d timeout=%0b, want 16 16", gotData.size(), obsPops, obsTimeout);
    end
    nChecks++;
    if (obsMaxOut != DEPTH) begin
      nFails++;
      $display("FAIL bp_outstanding: max popped-not-accepted %0d, want %0d", obsMaxOut, DEPTH);
    end
    for (int i = 0; i < gotData.size(); i++) begin
      nChecks++;
      if (gotData[i] !== words[i] || gotLast[i] != (i == 15)) begin
        nFails++;
        $display("FAIL bp_beat%0d: data %h last %0b, want %h last %0b", i, gotData[i], gotLast[i], words[i], i == 15);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] a;
    logic [2:0]  s;
    int beats, errSeen, actSeen;
    for (int n = 0; n < 6; n++) begin
      if (n == 0) begin a = 32'h0; s = 3'd6; end
      else if (n == 1) begin a = 32'h108; s = 3'd2; end
      else if (n % 2 == 0) begin a = $urandom & ~32'h7; s = 3'($urandom_range(5, 7)); end
      else begin
        s = 3'($urandom_range(1, 4));
        beats = 1 << s;
        a = ($urandom & ~32'hFF) + 32'(8 * $urandom_range(1, beats - 1));
      end
      req_valid = 1; req_addr = a; req_size = s;
      @(negedge Clk);
      nChecks++;
      if (req_ready !== 1'b1 || req_err !== 1'b1) begin
        nFails++;
        $display("FAIL illegal%0d_err: ready=%0b err=%0b for addr %h size %0d, want 1 1", n, req_ready, req_err, a, s);
      end
      @(posedge Clk); #1;
      req_valid = 0;
      errSeen = 0; actSeen = 0;
      repeat (3) begin
        @(negedge Clk);
        errSeen += int'(req_err);
        actSeen += int'(PIM_AddrReq) + int'(busy) + int'(PIM_RdFIFO_Pop);
      end
      nChecks++;
      if (errSeen != 0 || actSeen != 0) begin
        nFails++;
        $display("FAIL illegal%0d_after: err cycles %0d activity %0d, want 0 0", n, errSeen, actSeen);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_empty_toggle();
    int pwe0;
    pwe0 = popWhileEmpty;
    run_read($urandom & ~32'h7F, 3'd4, 0, 2, 0, 1, 0, 1'b0);
    nChecks++;
    if (obsTimeout || gotData.size() != 16 || popWhileEmpty != pwe0) begin
      nFails++;
      $display("FAIL empty_toggle: beats %0d pops-while-empty %0d timeout=%0b, want 16 0", gotData.size(), popWhileEmpty - pwe0, obsTimeout);
    end
    for (int i = 0; i < gotData.size(); i++) begin
      nChecks++;
      if (gotData[i] !== words[i]) begin
        nFails++;
        $display("FAIL empty_beat%0d: data %h, want %h", i, gotData[i], words[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] s;
    int beats, lat, bad, pwe0;
    for (int n = 0; n < 8; n++) begin
      s = 3'($urandom_range(0, 4));
      beats = 1 << s;
      lat = $urandom_range(0, 3);
      pwe0 = popWhileEmpty;
      run_read($urandom & ~32'h7F, s, lat, 2, 0, 2, 0, 1'b0);
      bad = 0;
      for (int i = 0; i < gotData.size(); i++)
        if (gotData[i] !== words[i] || gotLast[i] != (i == beats - 1)) bad++;
      nChecks++;
      if (obsTimeout || gotData.size() != beats || bad != 0 || obsMaxOut > DEPTH ||
          popWhileEmpty != pwe0 || obsNotIdleAfter) begin
        nFails++;
        $display("FAIL random%0d: size %0d lat %0d beats %0d/%0d bad %0d maxOut %0d timeout=%0b notIdle=%0b",
                 n, s, lat, gotData.size(), beats, bad, obsMaxOut, obsTimeout, obsNotIdleAfter);
      end
    end
  endtask

  task automatic test_initdone();
    int rdy;
    run_read(32'h40, 3'd2, 2, 2, 0, 2, 0, 1'b1);
    nChecks++;
    if (obsTimeout || gotData.size() != 4 || gotData[0] !== words[0] || gotData[3] !== words[3]) begin
      nFails++;
      $display("FAIL initdrop_complete: beats %0d timeout=%0b, want 4 in order", gotData.size(), obsTimeout);
    end
    req_valid = 1; req_addr = 32'h0; req_size = 3'd0;
    rdy = 0;
    repeat (5) begin
      @(negedge Clk);
      rdy += int'(req_ready) + int'(busy);
      @(posedge Clk); #1;
    end
    req_valid = 0;
    nChecks++;
    if (rdy != 0) begin
      nFails++;
      $display("FAIL initdrop_hold: ready/busy cycles %0d with InitDone=0, want 0", rdy);
    end
    PIM_InitDone = 1;
    @(negedge Clk);
    nChecks++;
    if (req_ready !== 1'b1) begin
      nFails++;
      $display("FAIL initdrop_resume: ready=%0b, want 1", req_ready);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid();
    int stray;
    run_read(32'h200, 3'd3, 1, 0, 0, 0, 3, 1'b0);
    nChecks++;
    if (gotData.size() != 3 || gotData[0] !== words[0] || gotData[2] !== words[2]) begin
      nFails++;
      $display("FAIL rstmid_prefix: %0d beats before reset, want 3 in order", gotData.size());
    end
    Rst = 1;
    #1;
    nChecks++;
    if ({req_ready, req_err, rd_valid, rd_last, busy, PIM_AddrReq, PIM_RdFIFO_Pop,
         PIM_RdFIFO_Flush} !== 8'b0 || PIM_RNW !== 1'b1 || PIM_Addr !== 32'h0 || PIM_Size !== 4'h0) begin
      nFails++;
      $display("FAIL rstmid_outputs: vld=%0b busy=%0b pop=%0b areq=%0b addr=%h size=%h rnw=%0b, want 0s and rnw=1",
               rd_valid, busy, PIM_RdFIFO_Pop, PIM_AddrReq, PIM_Addr, PIM_Size, PIM_RNW);
    end
    stray = 0;
    repeat (2) begin
      @(negedge Clk);
      stray += int'(PIM_RdFIFO_Pop) + int'(rd_valid);
    end
    @(posedge Clk); #1;
    Rst = 0;
    @(negedge Clk);
    nChecks++;
    if (stray != 0 || PIM_RdFIFO_Flush !== 1'b1 || req_ready !== 1'b0) begin
      nFails++;
      $display("FAIL rstmid_flush: stray %0d flush=%0b ready=%0b, want 0 1 0", stray, PIM_RdFIFO_Flush, req_ready);
    end
    @(posedge Clk); #1;
    run_read($urandom & ~32'h3F, 3'd3, $urandom_range(0, 2), 2, 0, 2, 0, 1'b0);
    nChecks++;
    if (obsTimeout || gotData.size() != 8 || obsPops != 8) begin
      nFails++;
      $display("FAIL rstmid_next: beats %0d pops %0d timeout=%0b, want 8 8", gotData.size(), obsPops, obsTimeout);
    end
    for (int i = 0; i < gotData.size(); i++) begin
      nChecks++;
      if (gotData[i] !== words[i] || gotLast[i] != (i == 7)) begin
        nFails++;
        $display("FAIL rstmid_beat%0d: data %h last %0b, want %h last %0b", i, gotData[i], gotLast[i], words[i], i == 7);
      end
    end
  endtask

  initial begin
    Rst = 0; req_valid = 0; req_addr = '0; req_size = '0; rd_ready = 0;
    PIM_AddrAck = 0; PIM_RdFIFO_Empty = 0; PIM_RdFIFO_Latency = 2'd0;
    PIM_RdFIFO_Data = '0; PIM_InitDone = 1;
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal();
    test_empty_toggle();
    test_random();
    test_initdone();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
